program_loader: RTL and testbench



---
 rtl/program_loader_pkg.sv | 26 ++
 rtl/program_loader_word_assembler.sv | 58 +++++
 rtl/program_loader.sv | 191 +++++++++++++++++++
 tb/tb_program_loader.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/program_loader_pkg.sv
// program_loader_pkg
// Shared definitions for the boot-time program loader: FSM state encoding,
// default word geometry and the running-checksum helpers.
package program_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RECV  = 3'd1,
        ST_WRITE = 3'd2,
        ST_CHECK = 3'd3,
        ST_RUN   = 3'd4,
        ST_ERROR = 3'd5
    } state_t;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int BYTES_PER_WORD     = DEFAULT_DATA_WIDTH / 8;

    // Seed of the running XOR checksum; the count byte is folded in first.
    localparam logic [7:0] CHECKSUM_INIT = 8'h00;

    // Fold one stream byte into the running checksum.
    function automatic logic [7:0] csum_fold(input logic [7:0] csum, input logic [7:0] b);
        return csum ^ b;
    endfunction

endpackage

// File: rtl/program_loader_word_assembler.sv
// program_loader_word_assembler
// Places incoming stream bytes into lanes of a word, least-significant first.
// Ports:
//   clock, reset      - clock and async active-low reset
//   clear             - synchronous clear of lane index and partial word
//   byte_valid        - a data byte is being accepted this cycle
//   byte_data         - the byte being accepted
//   word_next         - partial word including the byte accepted this cycle
//   word_done         - this byte completes the word
module program_loader_word_assembler #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic [DATA_WIDTH-1:0] word_next,
    output logic                  word_done
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    logic [IDX_W-1:0]      byte_idx_r;
    logic [DATA_WIDTH-1:0] word_r;

    // Merge the accepted byte into its lane and flag the last lane.
    always_comb begin
        word_next = word_r;
        word_done = 1'b0;
        if (byte_valid) begin
            word_next[{byte_idx_r, 3'b000} +: 8] = byte_data;
            word_done = (byte_idx_r == IDX_W'(BYTES - 1));
        end else begin
            word_next = word_r;
            word_done = 1'b0;
        end
    end

    // Lane index and partial word; the index wraps to 0 after the last lane.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            byte_idx_r <= '0;
            word_r     <= '0;
        end else if (clear) begin
            byte_idx_r <= '0;
            word_r     <= '0;
        end else if (byte_valid) begin
            word_r     <= word_next;
            byte_idx_r <= word_done ? '0 : byte_idx_r + IDX_W'(1'b1);
        end else begin
            byte_idx_r <= byte_idx_r;
            word_r     <= word_r;
        end
    end

endmodule

// File: rtl/program_loader.sv
// program_loader
// Holds the CPU in reset while a program image arrives as a byte stream
// (count byte, N little-endian words, XOR checksum byte), writes each word
// to unified memory and releases the CPU once the checksum matches.
// Ports:
//   clock, reset                - clock, async active-low reset
//   in_valid/in_data/in_ready   - byte stream handshake
//   reload                      - re-enter load mode (honoured in RUN/ERROR)
//   mem_write_enable/address/data - memory write port (values held when idle)
//   cpu_reset                   - active-high hold of the CPU
//   load_done / load_error      - image verified / checksum mismatch
module program_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int BASE_ADDR  = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    input  logic                  reload,
    output logic                  mem_write_enable,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    output logic                  cpu_reset,
    output logic                  load_done,
    output logic                  load_error
);
    import program_loader_pkg::*;

    state_t                state_r, state_next_s;
    logic [7:0]            count_r, count_next_s;
    logic [7:0]            word_idx_r, word_idx_next_s;
    logic [7:0]            csum_r, csum_next_s;
    logic                  mem_we_r, mem_we_next_s;
    logic [ADDR_WIDTH-1:0] mem_addr_r, mem_addr_next_s;
    logic [DATA_WIDTH-1:0] mem_data_r, mem_data_next_s;
    logic                  cpu_reset_r, cpu_reset_next_s;
    logic                  load_done_r, load_done_next_s;
    logic                  load_error_r, load_error_next_s;

    logic                  in_ready_s;
    logic                  accept_s;
    logic                  asm_clear_s;
    logic                  asm_valid_s;
    logic [DATA_WIDTH-1:0] word_next_s;
    logic                  word_done_s;

    // Ready is a pure decode of the current state.
    always_comb begin
        in_ready_s = 1'b0;
        case (state_r)
            ST_IDLE, ST_RECV, ST_CHECK: in_ready_s = 1'b1;
            default:                    in_ready_s = 1'b0;
        endcase
    end

    assign accept_s    = in_valid && in_ready_s;
    assign asm_clear_s = (state_r == ST_IDLE);
    assign asm_valid_s = accept_s && (state_r == ST_RECV);

    program_loader_word_assembler #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_word_assembler (
        .clock      (clock),
        .reset      (reset),
        .clear      (asm_clear_s),
        .byte_valid (asm_valid_s),
        .byte_data  (in_data),
        .word_next  (word_next_s),
        .word_done  (word_done_s)
    );

    // Next-state and next-output logic of the load FSM.
    always_comb begin
        state_next_s      = state_r;
        count_next_s      = count_r;
        word_idx_next_s   = word_idx_r;
        csum_next_s       = csum_r;
        mem_we_next_s     = 1'b0;
        mem_addr_next_s   = mem_addr_r;
        mem_data_next_s   = mem_data_r;
        cpu_reset_next_s  = cpu_reset_r;
        load_done_next_s  = load_done_r;
        load_error_next_s = load_error_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    count_next_s    = in_data;
                    csum_next_s     = csum_fold(CHECKSUM_INIT, in_data);
                    word_idx_next_s = 8'd0;
                    state_next_s    = (in_data == 8'd0) ? ST_CHECK : ST_RECV;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RECV: begin
                if (accept_s) begin
                    csum_next_s = csum_fold(csum_r, in_data);
                    if (word_done_s) begin
                        // Launch the write so it appears the cycle after the last byte.
                        state_next_s    = ST_WRITE;
                        mem_we_next_s   = 1'b1;
                        mem_addr_next_s = ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(word_idx_r);
                        mem_data_next_s = word_next_s;
                    end else begin
                        state_next_s = ST_RECV;
                    end
                end else begin
                    state_next_s = ST_RECV;
                end
            end
            ST_WRITE: begin
                if (word_idx_r == (count_r - 8'd1)) begin
                    state_next_s = ST_CHECK;
                end else begin
                    word_idx_next_s = word_idx_r + 8'd1;
                    state_next_s    = ST_RECV;
                end
            end
            ST_CHECK: begin
                if (accept_s) begin
                    if (in_data == csum_r) begin
                        state_next_s     = ST_RUN;
                        cpu_reset_next_s = 1'b0;
                        load_done_next_s = 1'b1;
                    end else begin
                        state_next_s      = ST_ERROR;
                        cpu_reset_next_s  = 1'b1;
                        load_error_next_s = 1'b1;
                    end
                end else begin
                    state_next_s = ST_CHECK;
                end
            end
            ST_RUN, ST_ERROR: begin
                if (reload) begin
                    state_next_s      = ST_IDLE;
                    cpu_reset_next_s  = 1'b1;
                    load_done_next_s  = 1'b0;
                    load_error_next_s = 1'b0;
                end else begin
                    state_next_s = state_r;
                end
            end
            default: begin
                state_next_s      = ST_IDLE;
                cpu_reset_next_s  = 1'b1;
                load_done_next_s  = 1'b0;
                load_error_next_s = 1'b0;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            count_r      <= 8'd0;
            word_idx_r   <= 8'd0;
            csum_r       <= CHECKSUM_INIT;
            mem_we_r     <= 1'b0;
            mem_addr_r   <= '0;
            mem_data_r   <= '0;
            cpu_reset_r  <= 1'b1;
            load_done_r  <= 1'b0;
            load_error_r <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            count_r      <= count_next_s;
            word_idx_r   <= word_idx_next_s;
            csum_r       <= csum_next_s;
            mem_we_r     <= mem_we_next_s;
            mem_addr_r   <= mem_addr_next_s;
            mem_data_r   <= mem_data_next_s;
            cpu_reset_r  <= cpu_reset_next_s;
            load_done_r  <= load_done_next_s;
            load_error_r <= load_error_next_s;
        end
    end

    assign in_ready         = in_ready_s;
    assign mem_write_enable = mem_we_r;
    assign mem_address      = mem_addr_r;
    assign mem_write_data   = mem_data_r;
    assign cpu_reset        = cpu_reset_r;
    assign load_done        = load_done_r;
    assign load_error       = load_error_r;

endmodule

// File: tb/tb_program_loader.sv
// Directed testbench for program_loader. Two instances share the stream:
// dut_a at BASE_ADDR 0x00 and dut_b at BASE_ADDR 0xFE (address wrap).
module tb_program_loader;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        reload = 1'b0;

    logic        a_in_ready, a_we, a_cpu_reset, a_done, a_err;
    logic [7:0]  a_addr;
    logic [31:0] a_data;
    logic        b_in_ready, b_we, b_cpu_reset, b_done, b_err;
    logic [7:0]  b_addr;
    logic [31:0] b_data;

    int total = 0;
    int bad = 0;
    int wr_count_a = 0;
    int ready_viol = 0;

    always #5 clock = ~clock;

    program_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .BASE_ADDR(0)) dut_a (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(a_in_ready), .reload(reload), .mem_write_enable(a_we),
        .mem_address(a_addr), .mem_write_data(a_data), .cpu_reset(a_cpu_reset),
        .load_done(a_done), .load_error(a_err)
    );

    program_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .BASE_ADDR(254)) dut_b (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(b_in_ready), .reload(reload), .mem_write_enable(b_we),
        .mem_address(b_addr), .mem_write_data(b_data), .cpu_reset(b_cpu_reset),
        .load_done(b_done), .load_error(b_err)
    );

    // Write counter and ready-during-write monitor, sampled mid-cycle.
    always @(negedge clock) begin
        if (a_we === 1'b1) wr_count_a <= wr_count_a + 1;
        if (a_we === 1'b1 && a_in_ready !== 1'b0) ready_viol <= ready_viol + 1;
    end

    // Present one byte after 'gap' idle cycles; returns 1ns after the accepting edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        n = 0;
        repeat (gap) begin
            @(negedge clock);
            in_valid = 1'b0;
        end
        @(negedge clock);
        in_valid = 1'b1;
        in_data  = b;
        while (a_in_ready !== 1'b1 && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (n >= 20) begin
            total++; bad++;
            $display("FAIL send_byte_timeout byte=%h in_ready=%b required=1", b, a_in_ready);
        end
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic pulse_reload();
        @(negedge clock);
        reload = 1'b1;
        @(posedge clock);
        #1;
        reload = 1'b0;
    endtask

    task automatic test_reset();
        in_valid = 1'b1;
        in_data  = 8'h55;
        repeat (4) @(posedge clock);
        #1;
        total++; if (a_cpu_reset !== 1'b1) begin bad++; $display("FAIL rst_cpu_reset got=%b exp=1", a_cpu_reset); end
        total++; if (a_we !== 1'b0) begin bad++; $display("FAIL rst_we got=%b exp=0", a_we); end
        total++; if (a_addr !== 8'h00) begin bad++; $display("FAIL rst_addr got=%h exp=00", a_addr); end
        total++; if (a_data !== 32'h0) begin bad++; $display("FAIL rst_data got=%h exp=0", a_data); end
        total++; if (a_done !== 1'b0 || a_err !== 1'b0) begin bad++; $display("FAIL rst_flags got=%b%b exp=00", a_done, a_err); end
        total++; if (wr_count_a != 0) begin bad++; $display("FAIL rst_no_write got=%0d exp=0", wr_count_a); end
        @(negedge clock);
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        total++; if (a_in_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready got=%b exp=1", a_in_ready); end
    endtask

    task automatic test_single_word();
        int w0;
        w0 = wr_count_a;
        send_byte(8'h01, 0);
        send_byte(8'h78, 0);
        send_byte(8'h56, 0);
        send_byte(8'h34, 0);
        send_byte(8'h12, 0);
        total++; if (a_we !== 1'b1) begin bad++; $display("FAIL sw_we got=%b exp=1", a_we); end
        total++; if (a_addr !== 8'h00) begin bad++; $display("FAIL sw_addr got=%h exp=00", a_addr); end
        total++; if (a_data !== 32'h12345678) begin bad++; $display("FAIL sw_data got=%h exp=12345678", a_data); end
        total++; if (b_addr !== 8'hFE) begin bad++; $display("FAIL sw_addr_b got=%h exp=fe", b_addr); end
        total++; if (a_in_ready !== 1'b0) begin bad++; $display("FAIL sw_ready_in_write got=%b exp=0", a_in_ready); end
        send_byte(8'h09, 0);
        total++; if (a_cpu_reset !== 1'b0) begin bad++; $display("FAIL sw_cpu_reset got=%b exp=0", a_cpu_reset); end
        total++; if (a_done !== 1'b1 || a_err !== 1'b0) begin bad++; $display("FAIL sw_flags got=%b%b exp=10", a_done, a_err); end
        total++; if (wr_count_a - w0 != 1) begin bad++; $display("FAIL sw_write_count got=%0d exp=1", wr_count_a - w0); end
        total++; if (a_data !== 32'h12345678) begin bad++; $display("FAIL sw_data_hold got=%h exp=12345678", a_data); end
    endtask

    task automatic test_reload_wins();
        @(negedge clock);
        reload = 1'b1;
        in_valid = 1'b1;
        in_data = 8'hA5;
        total++; if (a_in_ready !== 1'b0) begin bad++; $display("FAIL rl_ready_in_run got=%b exp=0", a_in_ready); end
        @(posedge clock);
        #1;
        reload = 1'b0;
        in_valid = 1'b0;
        total++; if (a_cpu_reset !== 1'b1 || a_done !== 1'b0) begin bad++; $display("FAIL rl_state got=%b%b exp=10", a_cpu_reset, a_done); end
        total++; if (a_in_ready !== 1'b1) begin bad++; $display("FAIL rl_idle_ready got=%b exp=1", a_in_ready); end
    endtask

    task automatic test_zero_count();
        int w0;
        w0 = wr_count_a;
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        total++; if (a_done !== 1'b1 || a_cpu_reset !== 1'b0) begin bad++; $display("FAIL zc_run got=%b%b exp=10", a_done, a_cpu_reset); end
        total++; if (wr_count_a != w0) begin bad++; $display("FAIL zc_no_write got=%0d exp=%0d", wr_count_a, w0); end
        pulse_reload();
        send_byte(8'h00, 0);
        send_byte(8'h05, 0);
        total++; if (a_err !== 1'b1 || a_done !== 1'b0) begin bad++; $display("FAIL zc_error got=%b%b exp=10", a_err, a_done); end
        total++; if (a_cpu_reset !== 1'b1) begin bad++; $display("FAIL zc_err_cpu_reset got=%b exp=1", a_cpu_reset); end
        total++; if (a_in_ready !== 1'b0) begin bad++; $display("FAIL zc_err_ready got=%b exp=0", a_in_ready); end
    endtask

    task automatic test_error_reload();
        pulse_reload();
        total++; if (a_err !== 1'b0) begin bad++; $display("FAIL er_err_clear got=%b exp=0", a_err); end
        send_byte(8'h01, 0);
        send_byte(8'h78, 0);
        send_byte(8'h56, 0);
        send_byte(8'h34, 0);
        send_byte(8'h12, 0);
        send_byte(8'h09, 0);
        total++; if (a_done !== 1'b1 || a_err !== 1'b0 || a_cpu_reset !== 1'b0) begin bad++; $display("FAIL er_reload_done got=%b%b%b exp=100", a_done, a_err, a_cpu_reset); end
    endtask

    task automatic test_two_word_gap();
        pulse_reload();
        send_byte(8'h02, 1);
        send_byte(8'hAA, 1);
        send_byte(8'hBB, 1);
        send_byte(8'hCC, 1);
        send_byte(8'hDD, 1);
        total++; if (b_we !== 1'b1 || b_addr !== 8'hFE) begin bad++; $display("FAIL tw_w0_addr got=%b/%h exp=1/fe", b_we, b_addr); end
        total++; if (b_data !== 32'hDDCCBBAA) begin bad++; $display("FAIL tw_w0_data got=%h exp=ddccbbaa", b_data); end
        send_byte(8'h11, 1);
        send_byte(8'h22, 1);
        send_byte(8'h33, 1);
        send_byte(8'h44, 1);
        total++; if (b_we !== 1'b1 || b_addr !== 8'hFF) begin bad++; $display("FAIL tw_w1_addr got=%b/%h exp=1/ff", b_we, b_addr); end
        total++; if (b_data !== 32'h44332211) begin bad++; $display("FAIL tw_w1_data got=%h exp=44332211", b_data); end
        total++; if (a_addr !== 8'h01) begin bad++; $display("FAIL tw_w1_addr_a got=%h exp=01", a_addr); end
        send_byte(8'h46, 1);
        total++; if (a_done !== 1'b1 || b_done !== 1'b1) begin bad++; $display("FAIL tw_done got=%b%b exp=11", a_done, b_done); end
        total++; if (ready_viol != 0) begin bad++; $display("FAIL tw_ready_in_write got=%0d exp=0", ready_viol); end
    endtask

    task automatic test_reset_midload();
        pulse_reload();
        send_byte(8'h01, 0);
        send_byte(8'h78, 0);
        send_byte(8'h56, 0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        total++; if (a_cpu_reset !== 1'b1 || a_data !== 32'h0) begin bad++; $display("FAIL ml_async got=%b/%h exp=1/0", a_cpu_reset, a_data); end
        @(negedge clock);
        reset = 1'b1;
        send_byte(8'h01, 0);
        send_byte(8'hEF, 0);
        send_byte(8'hBE, 0);
        send_byte(8'hAD, 0);
        send_byte(8'hDE, 0);
        total++; if (a_data !== 32'hDEADBEEF || a_addr !== 8'h00) begin bad++; $display("FAIL ml_reload_word got=%h/%h exp=deadbeef/00", a_data, a_addr); end
        send_byte(8'h23, 0);
        total++; if (a_done !== 1'b1 || a_cpu_reset !== 1'b0) begin bad++; $display("FAIL ml_done got=%b%b exp=10", a_done, a_cpu_reset); end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_reload_wins();
        test_zero_count();
        test_error_reload();
        test_two_word_gap();
        test_reset_midload();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

endmodule
